// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the round-robin arbiter
package arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int ID_W            = clog2(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first unmasked request at or after start, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && req[j] && !mask[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - locking round-robin arbiter with registered one-hot grant
// Optional hold-timeout preemption enabled by defining ARB_TIMEOUT_EN.
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [clog2(NUM_REQ)-1:0]  gnt_id,
    output logic                       preempt
);

    localparam int IW = clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr, ptr_nxt, id_nxt, owner_inc, pick_start, pick_id;
    logic [NUM_REQ-1:0] gnt_nxt, pick_mask, pick_gnt;
    logic               pick_found, owner_req, timeout, preempt_nxt;

    assign owner_inc = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign owner_req = |(req & gnt);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = clog2(MAX_HOLD) + 1;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          others;

    assign others  = |(req & ~gnt);
    assign timeout = (state == OWN) && owner_req && others && (hold_cnt == HW'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    // While owning, the same encoder serves handover: owner masked, search from owner+1.
    always_comb begin
        pick_mask  = '0;
        pick_start = ptr;
        if (state == OWN) begin
            pick_mask  = gnt;
            pick_start = owner_inc;
        end
    end

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .start  (pick_start),
        .onehot (pick_gnt),
        .idx    (pick_id),
        .found  (pick_found)
    );

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        id_nxt      = gnt_id;
        ptr_nxt     = ptr;
        preempt_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_nxt    = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    gnt_nxt   = pick_gnt;
                    id_nxt    = pick_id;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            OWN: begin
                if (!owner_req || timeout) begin
                    ptr_nxt     = owner_inc;
                    preempt_nxt = timeout;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt    = '0;
`endif
                    if (pick_found) begin
                        gnt_nxt = pick_gnt;
                        id_nxt  = pick_id;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        id_nxt    = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (others && hold_cnt != HW'(MAX_HOLD - 1)) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= '0;
            preempt   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            gnt_id    <= id_nxt;
            ptr       <= ptr_nxt;
            preempt   <= preempt_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_arbiter_rr.sv
// tb/tb_arbiter_rr.sv - self-checking bench for arbiter_rr against a behavioural reference model
module tb_arbiter_rr;

    localparam int N    = 4;
    localparam int MAXH = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    int checks;
    int errors;

    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    arbiter_rr #(.NUM_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    // One clock edge of the specified arbitration rules, using integers for owner and pointer.
    task automatic model_step(input logic [N-1:0] r);
        int          start;
        int          pick;
        logic [N-1:0] elig;
        bit          others;
        bit          tmo;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            start = m_ptr;
            elig  = r;
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
            tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo = r[m_owner] && others && (m_hold >= MAXH - 1);
`endif
            if (r[m_owner] && !tmo) begin
                if (others && m_hold < MAXH - 1) m_hold++;
                return;
            end
            m_ptr = (m_owner + 1) % N;
            start = m_ptr;
            elig  = r;
            elig[m_owner] = 1'b0;
            m_pre = tmo;
        end
        pick = -1;
        for (int k = 0; k < N; k++) begin
            if (pick < 0 && elig[(start + k) % N]) pick = (start + k) % N;
        end
        m_owner = pick;
        m_hold  = 0;
    endtask

    function automatic logic [7:0] exp_vec();
        logic [N-1:0] g;
        logic [1:0]   id;
        g  = '0;
        id = 2'd0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id         = 2'(m_owner);
        end
        return {g, |g, id, m_pre};
    endfunction

    task automatic tick(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, gnt_valid, gnt_id, preempt} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", {gnt, gnt_valid, gnt_id, preempt}, 8'b0);
        end
        rst = 1'b0;
        tick(4'b0010);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL reset_pre_grant: gnt got %b want 0010", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, gnt_valid, gnt_id} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got %b want 0000000", {gnt, gnt_valid, gnt_id});
        end
        #1;
        rst = 1'b0;
        model_reset();
        tick(4'b0100);
        checks++;
        if ({gnt, gnt_valid, gnt_id} !== 7'b0100_1_10) begin
            errors++;
            $display("FAIL reset_regrant: got %b want 0100110", {gnt, gnt_valid, gnt_id});
        end
    endtask

    task automatic test_single();
        logic [N-1:0] seq [3];
        seq = '{4'b0001, 4'b0000, 4'b1111};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(seq[i]);
            checks++;
            if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                errors++;
                $display("FAIL single[%0d]: got %b want %b", i, {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
            end
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL single_ptr: gnt got %b want 0010", gnt);
        end
        tick(4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] rq [8];
        logic [N-1:0] eg [8];
        rq = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111};
        eg = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(rq[i]);
            checks++;
            if (gnt !== eg[i] || {gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                errors++;
                $display("FAIL rotate[%0d]: got %b want gnt %b model %b", i,
                         {gnt, gnt_valid, gnt_id, preempt}, eg[i], exp_vec());
            end
        end
    endtask

    task automatic test_lock_wrap();
        logic [N-1:0] rq [5];
        logic [N-1:0] eg [5];
        rq = '{4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0000};
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(rq[i]);
            checks++;
            if (gnt !== eg[i] || {gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                errors++;
                $display("FAIL lock_wrap[%0d]: got %b want gnt %b model %b", i,
                         {gnt, gnt_valid, gnt_id, preempt}, eg[i], exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] eg [6];
        logic         ep [6];
`ifdef ARB_TIMEOUT_EN
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(4'b0011);
            checks++;
            if (gnt !== eg[i] || preempt !== ep[i] || {gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout[%0d]: got gnt %b pre %b want gnt %b pre %b", i, gnt, preempt, eg[i], ep[i]);
            end
        end
        tick(4'b0000);
    endtask

    task automatic test_lone();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            tick(4'b1000);
            if (i > 0) begin
                checks++;
                if (gnt !== 4'b1000 || preempt !== 1'b0 || {gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                    errors++;
                    $display("FAIL lone[%0d]: got gnt %b pre %b want gnt 1000 pre 0", i, gnt, preempt);
                end
            end
        end
        tick(4'b0000);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = '0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            tick(r);
            checks++;
            if ({gnt, gnt_valid, gnt_id, preempt} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: req %b got %b want %b", i, r,
                         {gnt, gnt_valid, gnt_id, preempt}, exp_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_lock_wrap();
        test_timeout();
        test_lone();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
